// File: rtl/spi_txn_arbiter_if.sv
// spi_txn_arbiter_if: bundles the requester-side and SPI-engine-side signals
// of spi_txn_arbiter.
//   master modport : arbiter view (drives grants, responses, engine controls)
//   slave modport  : environment view (requesters + SPI engine)
// Signals:
//   req/req_tx/req_rx [N_REQ]  request level and direction per requester
//   req_wdata [16*N_REQ]       frame per requester, slice i = [16*i+15:16*i]
//   req_freq  [2*N_REQ]        engine freq_control code per requester
//   gnt/resp_valid [N_REQ]     one-hot grant / one-hot completion pulse
//   resp_rdata, resp_err       received word and timeout flag
//   spi_* (to engine)          start pulses, cs_bar, tx data, freq
//   spi_rx_valid, spi_tx_done, spi_rx_data (from engine)
interface spi_txn_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_tx;
  logic [N_REQ-1:0]   req_rx;
  logic [16*N_REQ-1:0] req_wdata;
  logic [2*N_REQ-1:0] req_freq;
  logic [N_REQ-1:0]   gnt;
  logic [N_REQ-1:0]   resp_valid;
  logic [15:0]        resp_rdata;
  logic               resp_err;
  logic               spi_rx_start;
  logic               spi_tx_start;
  logic               spi_cs_bar;
  logic [15:0]        spi_tx_data;
  logic [1:0]         spi_freq;
  logic               spi_rx_valid;
  logic               spi_tx_done;
  logic [15:0]        spi_rx_data;

  modport master (
    input  req, req_tx, req_rx, req_wdata, req_freq,
    input  spi_rx_valid, spi_tx_done, spi_rx_data,
    output gnt, resp_valid, resp_rdata, resp_err,
    output spi_rx_start, spi_tx_start, spi_cs_bar, spi_tx_data, spi_freq
  );

  modport slave (
    output req, req_tx, req_rx, req_wdata, req_freq,
    output spi_rx_valid, spi_tx_done, spi_rx_data,
    input  gnt, resp_valid, resp_rdata, resp_err,
    input  spi_rx_start, spi_tx_start, spi_cs_bar, spi_tx_data, spi_freq
  );
endinterface

// File: rtl/spi_txn_arbiter.sv
// spi_txn_arbiter: round-robin arbiter/sequencer sharing one SPI engine among
// N_REQ requesters. Grants one eligible requester, pulses the engine start,
// waits for the rising edge of (rx_valid | tx_done), returns the received word,
// then holds an inter-frame gap of GAP_CYCLES before the next grant.
// Ports:
//   clk    system clock
//   reset  synchronous reset, active-high
//   bus    spi_txn_arbiter_if.master (requester handshake + engine controls)
// Parameters: N_REQ (2..8), GAP_CYCLES, TIMEOUT_CYCLES.
// Optional feature: define SPI_ARB_TIMEOUT_EN to abort a BUSY frame after
// TIMEOUT_CYCLES with resp_err=1; otherwise resp_err is tied 0 and BUSY waits
// indefinitely.
module spi_txn_arbiter #(
  parameter int N_REQ          = 4,
  parameter int GAP_CYCLES     = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input logic               clk,
  input logic               reset,
  spi_txn_arbiter_if.master bus
);
  localparam int unsigned NR = N_REQ;
  localparam int IW = $clog2(N_REQ);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  if (N_REQ < 2 || N_REQ > 8 || GAP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("spi_txn_arbiter: unsupported parameter combination");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_BUSY,
    S_DONE,
    S_GAP
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_resp_valid;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_rr;
  logic [15:0]      r_tx_data;
  logic [15:0]      r_resp_rdata;
  logic [1:0]       r_freq;
  logic             r_rx;
  logic             r_rx_start;
  logic             r_tx_start;
  logic             r_cs_bar;
  logic             r_level_d;
  logic [GW-1:0]    r_gap_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]    r_busy_cnt;
  logic             r_resp_err;
`endif

  logic [N_REQ-1:0] w_elig;
  logic             w_found;
  logic [IW-1:0]    w_pick;
  logic [N_REQ-1:0] w_pick_oh;
  logic [15:0]      w_pick_data;
  logic [1:0]       w_pick_freq;
  logic             w_pick_tx;
  logic             w_pick_rx;
  logic             w_level;
  logic             w_done;

  assign w_elig  = bus.req & (bus.req_tx | bus.req_rx);
  assign w_level = bus.spi_rx_valid | bus.spi_tx_done;
  // Only a fresh rising edge completes a frame; a level left high by the
  // previous frame is masked by the delayed copy.
  assign w_done  = w_level & ~r_level_d;

  // Round-robin pick: first pass looks at indices >= rr, second pass wraps
  // to the lowest eligible index.
  always_comb begin
    w_found     = 1'b0;
    w_pick      = '0;
    w_pick_oh   = '0;
    w_pick_data = '0;
    w_pick_freq = '0;
    w_pick_tx   = 1'b0;
    w_pick_rx   = 1'b0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (!w_found && w_elig[i] && (i >= 32'(r_rr))) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
      end
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (!w_found && w_elig[i]) begin
        w_found = 1'b1;
        w_pick  = IW'(i);
      end
    end
    for (int unsigned i = 0; i < NR; i++) begin
      if (w_found && (w_pick == IW'(i))) begin
        w_pick_oh[i] = 1'b1;
        w_pick_data  = bus.req_wdata[16*i +: 16];
        w_pick_freq  = bus.req_freq[2*i +: 2];
        w_pick_tx    = bus.req_tx[i];
        w_pick_rx    = bus.req_rx[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    r_level_d <= w_level;
    if (reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_resp_valid <= '0;
      r_idx        <= '0;
      r_rr         <= '0;
      r_tx_data    <= '0;
      r_resp_rdata <= '0;
      r_freq       <= 2'b00;
      r_rx         <= 1'b0;
      r_rx_start   <= 1'b0;
      r_tx_start   <= 1'b0;
      r_cs_bar     <= 1'b0;
      r_gap_cnt    <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
      r_busy_cnt   <= '0;
      r_resp_err   <= 1'b0;
`endif
    end else begin
      r_rx_start   <= 1'b0;
      r_tx_start   <= 1'b0;
      r_cs_bar     <= 1'b0;
      r_resp_valid <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt      <= w_pick_oh;
            r_idx      <= w_pick;
            r_tx_data  <= w_pick_data;
            r_freq     <= w_pick_freq;
            r_rx       <= w_pick_rx;
            // Start pulses are registered here so they coincide with ISSUE.
            r_cs_bar   <= 1'b1;
            r_tx_start <= w_pick_tx;
            r_rx_start <= w_pick_rx;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef SPI_ARB_TIMEOUT_EN
          r_busy_cnt <= '0;
`endif
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (w_done) begin
            r_resp_rdata <= r_rx ? bus.spi_rx_data : '0;
            r_resp_valid <= r_gnt;
`ifdef SPI_ARB_TIMEOUT_EN
            r_resp_err   <= 1'b0;
`endif
            r_state      <= S_DONE;
          end
`ifdef SPI_ARB_TIMEOUT_EN
          else if (r_busy_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            r_resp_rdata <= '0;
            r_resp_valid <= r_gnt;
            r_resp_err   <= 1'b1;
            r_state      <= S_DONE;
          end else begin
            r_busy_cnt <= r_busy_cnt + TW'(1);
          end
`endif
        end
        S_DONE: begin
          r_gnt     <= '0;
          r_rr      <= (r_idx == IW'(N_REQ - 1)) ? '0 : r_idx + IW'(1);
          r_gap_cnt <= '0;
          r_state   <= S_GAP;
        end
        S_GAP: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            r_state <= S_IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.gnt          = r_gnt;
  assign bus.resp_valid   = r_resp_valid;
  assign bus.resp_rdata   = r_resp_rdata;
  assign bus.spi_rx_start = r_rx_start;
  assign bus.spi_tx_start = r_tx_start;
  assign bus.spi_cs_bar   = r_cs_bar;
  assign bus.spi_tx_data  = r_tx_data;
  assign bus.spi_freq     = r_freq;
`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.resp_err     = r_resp_err;
`else
  assign bus.resp_err     = 1'b0;
`endif
endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Self-checking bench for spi_txn_arbiter with a loopback SPI engine model.
module tb_spi_txn_arbiter;
  localparam int G       = 8;
  localparam int ENG_LAT = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_txn_arbiter_if #(.N_REQ(4)) bus ();

  spi_txn_arbiter #(
    .N_REQ(4),
    .GAP_CYCLES(G),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  // Engine model: on a start pulse latch the frame, after ENG_LAT cycles raise
  // rx_valid/tx_done with the transmitted word looped back. Levels stay high
  // until the next start (or forever when eng_hold is set).
  logic        eng_hold = 1'b0, eng_stall = 1'b0, force_low = 1'b0;
  logic        eng_rxv = 1'b0, eng_txd = 1'b0, eng_pend = 1'b0;
  logic        eng_f_rx = 1'b0, eng_f_tx = 1'b0;
  logic [15:0] eng_buf = '0, eng_data = '0;
  int          eng_cnt = 0;

  always @(negedge clk) begin
    if (reset) begin
      eng_rxv = 1'b0; eng_txd = 1'b0; eng_pend = 1'b0; eng_cnt = 0; eng_data = '0;
    end else if (bus.spi_tx_start || bus.spi_rx_start) begin
      if (!eng_hold) begin eng_rxv = 1'b0; eng_txd = 1'b0; end
      eng_f_rx = bus.spi_rx_start; eng_f_tx = bus.spi_tx_start;
      eng_buf = bus.spi_tx_data; eng_pend = 1'b1; eng_cnt = ENG_LAT;
    end else if (eng_pend && !eng_stall) begin
      if (eng_cnt == 0) begin
        eng_data = eng_buf; eng_rxv = eng_f_rx; eng_txd = eng_f_tx; eng_pend = 1'b0;
      end else begin
        eng_cnt = eng_cnt - 1;
      end
    end
  end

  assign bus.spi_rx_valid = eng_rxv & ~force_low;
  assign bus.spi_tx_done  = eng_txd & ~force_low;
  assign bus.spi_rx_data  = eng_data;

  typedef struct {
    logic [3:0]  oh;
    logic [15:0] data;
    logic        err;
  } exp_t;
  exp_t sb[$];

  logic [3:0] grant_log[$];
  logic [1:0] start_freq[$];
  int         start_cyc[$];
  int         done_cyc[$];

  // Advance up to budget cycles or until n responses; log starts, pop and
  // compare the scoreboard on each response, and release the served request.
  task automatic run_frames(input int n, input int budget, output bit ok);
    exp_t e;
    int got = 0;
    grant_log.delete(); start_freq.delete(); start_cyc.delete(); done_cyc.delete();
    for (int c = 0; c < budget && got < n; c++) begin
      @(negedge clk);
      if (bus.spi_tx_start || bus.spi_rx_start) begin
        grant_log.push_back(bus.gnt);
        start_freq.push_back(bus.spi_freq);
        start_cyc.push_back(cyc);
      end
      if (bus.resp_valid != 4'b0000) begin
        got++;
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: resp_valid=%b, required no response", bus.resp_valid);
        end else begin
          e = sb.pop_front();
          checks++;
          if (bus.resp_valid !== e.oh) begin
            errors++; $display("FAIL resp_valid: got %b, expected %b", bus.resp_valid, e.oh);
          end
          checks++;
          if (bus.resp_rdata !== e.data) begin
            errors++; $display("FAIL resp_rdata: got %h, expected %h", bus.resp_rdata, e.data);
          end
          checks++;
          if (bus.resp_err !== e.err) begin
            errors++; $display("FAIL resp_err: got %b, expected %b", bus.resp_err, e.err);
          end
        end
        bus.req = bus.req & ~bus.resp_valid;
      end
    end
    ok = (got == n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.req = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.req = '0; bus.req_tx = '0; bus.req_rx = '0; bus.req_wdata = '0; bus.req_freq = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.resp_valid !== 4'b0000) begin
      errors++; $display("FAIL reset_gnt_resp: got gnt=%b resp_valid=%b, expected 0000 0000", bus.gnt, bus.resp_valid);
    end
    checks++;
    if ({bus.resp_err, bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got err/cs/txs/rxs=%b%b%b%b, expected 0000",
                         bus.resp_err, bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start);
    end
    checks++;
    if (bus.resp_rdata !== 16'h0 || bus.spi_tx_data !== 16'h0 || bus.spi_freq !== 2'b00) begin
      errors++; $display("FAIL reset_data: got rdata=%h tx_data=%h freq=%b, expected 0000 0000 00",
                         bus.resp_rdata, bus.spi_tx_data, bus.spi_freq);
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0000) begin
      errors++; $display("FAIL idle_no_req: got gnt=%b, expected 0000", bus.gnt);
    end
  endtask

  task automatic test_single_loopback();
    bit ok;
    @(negedge clk);
    bus.req_wdata[15:0] = 16'hA5C3; bus.req_freq[1:0] = 2'b10;
    bus.req_tx[0] = 1'b1; bus.req_rx[0] = 1'b1; bus.req[0] = 1'b1;
    sb.push_back(exp_t'{oh: 4'b0001, data: 16'hA5C3, err: 1'b0});
    @(negedge clk);
    checks++;
    if ({bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start} !== 3'b111 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL issue_latency: got cs/txs/rxs=%b%b%b gnt=%b, expected 111 0001",
                         bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start, bus.gnt);
    end
    checks++;
    if (bus.spi_tx_data !== 16'hA5C3 || bus.spi_freq !== 2'b10) begin
      errors++; $display("FAIL issue_data: got tx_data=%h freq=%b, expected a5c3 10", bus.spi_tx_data, bus.spi_freq);
    end
    bus.req_wdata[15:0] = 16'hFFFF;
    @(negedge clk);
    checks++;
    if ({bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start} !== 3'b000 || bus.gnt !== 4'b0001) begin
      errors++; $display("FAIL busy_ctrl: got cs/txs/rxs=%b%b%b gnt=%b, expected 000 0001",
                         bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start, bus.gnt);
    end
    run_frames(1, 100, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_done: got no response, expected 1 within 100 cycles"); end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [15:0] wd[4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0};
    logic [3:0]  tx = 4'b1011;
    logic [3:0]  rx = 4'b1101;
    logic [3:0]  oh;
    do_reset();
    @(negedge clk);
    bus.req_tx = tx; bus.req_rx = rx;
    bus.req_freq = {2'b11, 2'b10, 2'b01, 2'b00};
    for (int i = 0; i < 4; i++) begin
      bus.req_wdata[16*i +: 16] = wd[i];
      oh = 4'b0001 << i;
      sb.push_back(exp_t'{oh: oh, data: rx[i] ? wd[i] : 16'h0000, err: 1'b0});
    end
    bus.req = 4'b1111;
    run_frames(4, 400, ok);
    checks++;
    if (!ok || grant_log.size() != 4) begin
      errors++; $display("FAIL rr_count: got %0d grants, expected 4", grant_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        oh = 4'b0001 << i;
        checks++;
        if (grant_log[i] !== oh || start_freq[i] !== 2'(i)) begin
          errors++; $display("FAIL rr_order[%0d]: got gnt=%b freq=%b, expected %b %b", i, grant_log[i], start_freq[i], oh, 2'(i));
        end
        if (i > 0) begin
          checks++;
          if (start_cyc[i] - done_cyc[i-1] < G) begin
            errors++; $display("FAIL rr_gap[%0d]: got %0d cycles, expected >= %0d", i, start_cyc[i] - done_cyc[i-1], G);
          end
        end
      end
    end
  endtask

  task automatic test_no_direction();
    bit ok;
    @(negedge clk);
    bus.req_tx[1] = 1'b0; bus.req_rx[1] = 1'b0;
    bus.req_tx[2] = 1'b1; bus.req_rx[2] = 1'b0; bus.req_wdata[47:32] = 16'h0F0F;
    sb.push_back(exp_t'{oh: 4'b0100, data: 16'h0000, err: 1'b0});
    bus.req[1] = 1'b1; bus.req[2] = 1'b1;
    run_frames(1, 100, ok);
    checks++;
    if (!ok || grant_log.size() != 1 || grant_log[0] !== 4'b0100) begin
      errors++; $display("FAIL nodir_grant: got ok=%0d grants=%0d, expected ok=1 gnt=0100", ok, grant_log.size());
    end
    run_frames(1, 3 * G + 10, ok);
    checks++;
    if (ok || grant_log.size() != 0) begin
      errors++; $display("FAIL nodir_never: got %0d grants, expected 0", grant_log.size());
    end
    bus.req[1] = 1'b0;
  endtask

  task automatic test_rr_wrap();
    bit ok;
    @(negedge clk);
    bus.req_tx[0] = 1'b0; bus.req_rx[0] = 1'b1; bus.req_wdata[15:0]  = 16'h1111;
    bus.req_tx[3] = 1'b1; bus.req_rx[3] = 1'b1; bus.req_wdata[63:48] = 16'h3333;
    sb.push_back(exp_t'{oh: 4'b1000, data: 16'h3333, err: 1'b0});
    sb.push_back(exp_t'{oh: 4'b0001, data: 16'h1111, err: 1'b0});
    bus.req = 4'b1001;
    run_frames(2, 200, ok);
    checks++;
    if (!ok || grant_log.size() != 2 || grant_log[0] !== 4'b1000 || grant_log[1] !== 4'b0001) begin
      errors++; $display("FAIL rr_wrap: got ok=%0d grants=%0d, expected 1000 then 0001", ok, grant_log.size());
    end
  endtask

  task automatic test_stale_level();
    bit ok;
    @(negedge clk);
    eng_hold = 1'b1;
    bus.req_tx[1] = 1'b1; bus.req_rx[1] = 1'b1; bus.req_wdata[31:16] = 16'h1234;
    sb.push_back(exp_t'{oh: 4'b0010, data: 16'h1234, err: 1'b0});
    bus.req[1] = 1'b1;
    run_frames(1, 40, ok);
    checks++;
    if (ok || grant_log.size() != 1 || bus.gnt !== 4'b0010) begin
      errors++; $display("FAIL stale_no_done: got resp=%0d grants=%0d gnt=%b, expected 0 1 0010", ok, grant_log.size(), bus.gnt);
    end
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    force_low = 1'b0;
    run_frames(1, 40, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL stale_rearm: got no response, expected 1 after re-raise"); end
    eng_hold = 1'b0;
  endtask

  task automatic test_reset_busy();
    bit ok;
    bit started = 1'b0;
    @(negedge clk);
    eng_stall = 1'b1;
    bus.req_tx[2] = 1'b1; bus.req_rx[2] = 1'b0; bus.req_wdata[47:32] = 16'h5555;
    bus.req[2] = 1'b1;
    for (int c = 0; c < 30 && !started; c++) begin
      @(negedge clk);
      if (bus.spi_tx_start) started = 1'b1;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (!started || bus.gnt !== 4'b0100) begin
      errors++; $display("FAIL rb_busy: got started=%0d gnt=%b, expected 1 0100", started, bus.gnt);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.gnt !== 4'b0000 || bus.resp_valid !== 4'b0000 ||
        {bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start} !== 3'b000) begin
      errors++; $display("FAIL rb_after: got gnt=%b resp_valid=%b cs/txs/rxs=%b%b%b, expected 0000 0000 000",
                         bus.gnt, bus.resp_valid, bus.spi_cs_bar, bus.spi_tx_start, bus.spi_rx_start);
    end
    reset = 1'b0; bus.req = '0; eng_stall = 1'b0;
    run_frames(1, 30, ok);
    checks++;
    if (ok) begin errors++; $display("FAIL rb_no_resp: got a response, expected none"); end
  endtask

`ifdef SPI_ARB_TIMEOUT_EN
  task automatic test_timeout();
    bit ok;
    @(negedge clk);
    eng_stall = 1'b1;
    bus.req_tx[2] = 1'b1; bus.req_rx[2] = 1'b1; bus.req_wdata[47:32] = 16'hBEEF;
    sb.push_back(exp_t'{oh: 4'b0100, data: 16'h0000, err: 1'b1});
    bus.req[2] = 1'b1;
    run_frames(1, 100, ok);
    checks++;
    if (!ok || start_cyc.size() != 1 || done_cyc[0] - start_cyc[0] != 17) begin
      errors++; $display("FAIL timeout_latency: got ok=%0d delta=%0d, expected 1 17", ok,
                         (start_cyc.size() == 1 && done_cyc.size() == 1) ? done_cyc[0] - start_cyc[0] : -1);
    end
    eng_stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_single_loopback();
    test_round_robin();
    test_no_direction();
    test_rr_wrap();
    test_stale_level();
    test_reset_busy();
`ifdef SPI_ARB_TIMEOUT_EN
    test_timeout();
`endif
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending expectations, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
